// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dsa_state_t;

  // Width of the digit counter; a single-digit configuration still gets one bit.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice. Also exposes the carry into the
// slice MSB so the top level can form signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // Ripple the carry through the slice, bit by bit.
  always_comb begin
    // NOTE: blocking assignments here, so the carry ripples within one evaluation.
    // NOTE: every output gets a default first, so no latch can be inferred.
    logic carry;
    carry    = ci;
    s        = '0;
    c_msb_in = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock with the ripple carry held in a flop between digits.
// Optional build macro DSA_SAT_EN: on signed overflow the final sum is
// replaced by the saturated value matching the sign of operand A.
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

`ifdef DSA_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic a_sign;
`endif

  dsa_state_t       state;
  logic [CNT_W-1:0] cnt;
  // Operands shift right one digit per RUN cycle, so the current slice is
  // always at the bottom; this is the slice at index cnt*DIGIT of the
  // originally latched value.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  logic [DIGIT-1:0] s_dig;
  logic             co_dig;
  logic             c_msb_dig;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_slice (
    .x       (a_q[DIGIT-1:0]),
    .y       (b_q[DIGIT-1:0]),
    .ci      (carry_q),
    .s       (s_dig),
    .co      (co_dig),
    .c_msb_in(c_msb_dig)
  );

  // Control FSM, digit counter, operand/carry registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments, so every flop samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
`ifdef DSA_SAT_EN
      a_sign  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and force the carry-in.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef DSA_SAT_EN
            a_sign  <= a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          // Result digits enter at the top and move down, landing in place
          // after the last digit; intermediate sum values are not meaningful.
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= co_dig;
          sum     <= (sum >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= co_dig;
            ovf   <= c_msb_dig ^ co_dig;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
`ifdef DSA_SAT_EN
          if (ovf) sum <= a_sign ? SAT_NEG : SAT_POS;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed cases on WIDTH=8/DIGIT=1
// and WIDTH=16/DIGIT=4, then randomised operations for DIGIT in {1,2,4,8}.
module tb_digit_serial_adder;

  logic clk;
  logic rst_n;

  // Shared operand inputs for the four WIDTH=8 instances; each has its own start.
  logic [7:0] a8, b8;
  logic       sub8, cin8;
  logic       start8 [4];
  logic       busy8  [4];
  logic       done8  [4];
  logic [7:0] sum8   [4];
  logic       cout8  [4];
  logic       ovf8   [4];

  logic [15:0] a16, b16, sum16;
  logic        sub16, cin16, start16, busy16, done16, cout16, ovf16;

  int checks   = 0;
  int failures = 0;

  int lat, nbusy;
  int dpos [$];
  logic [15:0] es;
  logic        eco, eov;

  for (genvar g = 0; g < 4; g++) begin : g_dut8
    digit_serial_adder #(
      .WIDTH(8),
      .DIGIT(1 << g)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start8[g]),
      .sub  (sub8),
      .a    (a8),
      .b    (b8),
      .cin  (cin8),
      .busy (busy8[g]),
      .done (done8[g]),
      .sum  (sum8[g]),
      .cout (cout8[g]),
      .ovf  (ovf8[g])
    );
  end

  digit_serial_adder #(
    .WIDTH(16),
    .DIGIT(4)
  ) u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start16),
    .sub  (sub16),
    .a    (a16),
    .b    (b16),
    .cin  (cin16),
    .busy (busy16),
    .done (done16),
    .sum  (sum16),
    .cout (cout16),
    .ovf  (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input logic sv, input logic cv,
                                    output logic [15:0] s, output logic co, output logic ov);
    longint full, half, ua, ub, res, sa, sb, st;
    full = longint'(1) << w;
    half = full / 2;
    ua   = longint'(av) & (full - 1);
    ub   = longint'(bv) & (full - 1);
    if (sv) begin
      res = ua - ub;
      co  = (ua >= ub);
    end else begin
      res = ua + ub + longint'(cv);
      co  = (res >= full);
    end
    s  = 16'(res & (full - 1));
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    st = sv ? (sa - sb) : (sa + sb + longint'(cv));
    ov = (st >= half) || (st < -half);
`ifdef DSA_SAT_EN
    if (ov) s = 16'((sa < 0) ? half : half - 1);
`endif
  endfunction

  // One operation on 8-bit instance g; inputs are scrambled right after the
  // start edge. lat = edges from the start edge to done (-1 on timeout).
  task automatic do_op8(input int g, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic cv, output int l, output int nb);
    @(negedge clk);
    a8 = av; b8 = bv; sub8 = sv; cin8 = cv; start8[g] = 1'b1;
    @(posedge clk); #1;
    start8[g] = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    l = -1; nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (busy8[g]) nb++;
      if (done8[g]) begin l = k; break; end
    end
  endtask

  // One operation on the 16-bit instance; optionally pulses start at step pulse_k.
  task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic cv, input int pulse_k, output int l);
    @(negedge clk);
    a16 = av; b16 = bv; sub16 = sv; cin16 = cv; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    l = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start16 = (k == pulse_k);
      if (k == pulse_k) begin a16 = 16'h1234; b16 = 16'h4321; end
      if (done16) begin l = k; break; end
    end
    start16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0;
    a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b0;
    for (int g = 0; g < 4; g++) start8[g] = 1'b0;
    #12;

    // Reset state
    check("rst.busy8", busy8[0], 1'b0);
    check("rst.done8", done8[0], 1'b0);
    check("rst.sum8", sum8[0], 8'h00);
    check("rst.cout8", cout8[0], 1'b0);
    check("rst.ovf8", ovf8[0], 1'b0);
    check("rst.busy16", busy16, 1'b0);
    check("rst.sum16", sum16, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 3C + 0F + 1
    do_op8(0, 8'h3C, 8'h0F, 1'b0, 1'b1, lat, nbusy);
    check("add1.lat", lat, 9);
    check("add1.busy_cycles", nbusy, 8);
    check("add1.sum", sum8[0], 8'h4C);
    check("add1.cout", cout8[0], 1'b0);
    check("add1.ovf", ovf8[0], 1'b0);
    @(posedge clk); #1;
    check("add1.done_pulse", done8[0], 1'b0);
    check("add1.sum_hold", sum8[0], 8'h4C);

    // 7F + 01: positive overflow
    do_op8(0, 8'h7F, 8'h01, 1'b0, 1'b0, lat, nbusy);
`ifdef DSA_SAT_EN
    check("add2.sum", sum8[0], 8'h7F);
`else
    check("add2.sum", sum8[0], 8'h80);
`endif
    check("add2.ovf", ovf8[0], 1'b1);
    check("add2.cout", cout8[0], 1'b0);

    // 05 - 07: borrow
    do_op8(0, 8'h05, 8'h07, 1'b1, 1'b1, lat, nbusy);
    check("sub1.sum", sum8[0], 8'hFE);
    check("sub1.cout", cout8[0], 1'b0);
    check("sub1.ovf", ovf8[0], 1'b0);

    // 80 - 01: negative overflow
    do_op8(0, 8'h80, 8'h01, 1'b1, 1'b0, lat, nbusy);
`ifdef DSA_SAT_EN
    check("sub2.sum", sum8[0], 8'h80);
`else
    check("sub2.sum", sum8[0], 8'h7F);
`endif
    check("sub2.ovf", ovf8[0], 1'b1);
    check("sub2.cout", cout8[0], 1'b1);

    // WIDTH=16, DIGIT=4: FFFF + 0001 with a start pulse during RUN
    do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 2, lat);
    check("w16.lat", lat, 5);
    check("w16.sum", sum16, 16'h0000);
    check("w16.cout", cout16, 1'b1);
    check("w16.ovf", ovf16, 1'b0);
    @(posedge clk); #1;
    check("w16.busy_after", busy16, 1'b0);
    check("w16.sum_hold", sum16, 16'h0000);

    // start held high: back-to-back operations every 10 cycles
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b0; start8[0] = 1'b1;
    @(posedge clk); #1;
    dpos.delete();
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done8[0]) dpos.push_back(k);
      if (k == 19) start8[0] = 1'b0;
    end
    check("b2b.count", dpos.size(), 2);
    check("b2b.first", (dpos.size() > 0) ? dpos[0] : -1, 9);
    check("b2b.second", (dpos.size() > 1) ? dpos[1] : -1, 19);
    check("b2b.sum", sum8[0], 8'h33);
    repeat (3) @(posedge clk);

    // Asynchronous reset in the third RUN cycle
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h66; sub8 = 1'b0; cin8 = 1'b1; start8[0] = 1'b1;
    @(posedge clk); #1;
    start8[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("arst.busy_before", busy8[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", busy8[0], 1'b0);
    check("arst.done", done8[0], 1'b0);
    check("arst.sum", sum8[0], 8'h00);
    check("arst.cout", cout8[0], 1'b0);
    check("arst.ovf", ovf8[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op8(0, 8'h01, 8'h02, 1'b0, 1'b0, lat, nbusy);
    check("arst.relat", lat, 9);
    check("arst.resum", sum8[0], 8'h03);

    // Randomised operations, WIDTH=8, DIGIT in {1,2,4,8}
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [7:0] ra, rb;
        logic       rs, rc;
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        ref_model(8, {8'h00, ra}, {8'h00, rb}, rs, rc, es, eco, eov);
        do_op8(g, ra, rb, rs, rc, lat, nbusy);
        check($sformatf("rnd8.d%0d.lat", 1 << g), lat, 8 / (1 << g) + 1);
        check($sformatf("rnd8.d%0d.sum a=%h b=%h sub=%b cin=%b", 1 << g, ra, rb, rs, rc),
              sum8[g], es[7:0]);
        check($sformatf("rnd8.d%0d.cout", 1 << g), cout8[g], eco);
        check($sformatf("rnd8.d%0d.ovf", 1 << g), ovf8[g], eov);
      end
    end

    // Randomised operations, WIDTH=16, DIGIT=4
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ra, rb;
      logic        rs, rc;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      ref_model(16, ra, rb, rs, rc, es, eco, eov);
      do_op16(ra, rb, rs, rc, -1, lat);
      check("rnd16.lat", lat, 5);
      check($sformatf("rnd16.sum a=%h b=%h sub=%b cin=%b", ra, rb, rs, rc), sum16, es);
      check("rnd16.cout", cout16, eco);
      check("rnd16.ovf", ovf16, eov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
